// File: rtl/piezo_melody_pkg.sv
// Shared constants for the piezo melody sequencer:
// note table, melody ROM layout and contents.
package piezo_melody_pkg;

    localparam int NUM_NOTES = 8;
    localparam int ROM_DEPTH = 16;
    localparam int IDX_W     = $clog2(ROM_DEPTH);
    localparam int HP_W      = 12;
    localparam int TMR_W     = 24;

    localparam int REST_BIT  = 7;
    localparam int NOTE_MSB  = 6;
    localparam int NOTE_LSB  = 4;
    localparam int DUR_MSB   = 3;
    localparam int DUR_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NOTE,
        ST_GAP
    } state_t;

    function automatic logic [HP_W-1:0] note_half_period(input logic [2:0] n);
        logic [HP_W-1:0] hp;
        case (n)
            3'd0:    hp = 12'd1911;
            3'd1:    hp = 12'd1703;
            3'd2:    hp = 12'd1517;
            3'd3:    hp = 12'd1432;
            3'd4:    hp = 12'd1276;
            3'd5:    hp = 12'd1136;
            3'd6:    hp = 12'd1012;
            default: hp = 12'd956;
        endcase
        return hp;
    endfunction

    // C4 x1, rest x2, E4 x1, end marker.
    function automatic logic [7:0] melody_rom(input logic [IDX_W-1:0] idx);
        logic [7:0] e;
        case (idx)
            4'd0:    e = 8'h01;
            4'd1:    e = 8'h82;
            4'd2:    e = 8'h21;
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    // Lowest-numbered pressed button wins.
    function automatic logic [2:0] lowest_btn(input logic [NUM_NOTES-1:0] b);
        logic [2:0] n;
        n = 3'd0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (b[i]) n = 3'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles piezo every half_period cycles,
// restarting its phase whenever the requested tone changes.
module piezo_tone_gen
    import piezo_melody_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            piezo
);

    logic            en_q;
    logic [HP_W-1:0] hp_q;
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            piezo_q, piezo_d;
    logic            restart;

    // Next counter/output: clear when off, rephase on a new tone.
    always_comb begin
        restart = en && (!en_q || (half_period != hp_q));
        cnt_d   = cnt_q;
        piezo_d = piezo_q;
        if (!en || restart) begin
            cnt_d   = '0;
            piezo_d = 1'b0;
        end else if (cnt_q == hp_q - 1'b1) begin
            cnt_d   = '0;
            piezo_d = !piezo_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Tone request, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            hp_q    <= '0;
            cnt_q   <= '0;
            piezo_q <= 1'b0;
        end else begin
            en_q    <= en;
            hp_q    <= half_period;
            cnt_q   <= cnt_d;
            piezo_q <= piezo_d;
        end
    end

    assign piezo = piezo_q;

endmodule

// File: rtl/piezo_melody_ctrl.sv
// Melody sequencer with button override for the piezo buzzer;
// buttons pause the melody timers while they own the tone.
module piezo_melody_ctrl
    import piezo_melody_pkg::*;
#(
    parameter int TICK_UNIT  = 125000,
    parameter int GAP_CYCLES = 20000,
    parameter int LOOP       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_NOTES-1:0] btn,
    input  logic                 play_start,
    input  logic                 play_stop,
    output logic                 piezo,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_idx,
    output logic                 manual
);

    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    function automatic logic [TMR_W-1:0] note_load(input logic [3:0] dur);
        return TMR_W'(dur) * TMR_W'(TICK_UNIT) - TMR_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              busy_q, busy_d;
    logic              manual_q, manual_d;
    logic [7:0]        entry0, entry_nxt, entry_cur;
    logic              pause, at_last, restart;
    logic              tone_en_d;
    logic [HP_W-1:0]   tone_hp_d;

    // Melody state machine: note/gap timers, index advance, stop/start.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmr_d     = tmr_q;
        pause     = |btn;
        restart   = play_start && !play_stop;
        entry0    = melody_rom('0);
        entry_nxt = melody_rom(idx_q + 1'b1);
        at_last   = (idx_q == IDX_W'(ROM_DEPTH - 1))
                 || (entry_nxt[DUR_MSB:DUR_LSB] == '0);
        if (!play_stop && !play_start && !pause) begin
            unique case (state_q)
                ST_NOTE: begin
                    if (tmr_q == '0) begin
                        state_d = ST_GAP;
                        tmr_d   = GAP_LOAD;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end else if (!at_last) begin
                        state_d = ST_NOTE;
                        idx_d   = idx_q + 1'b1;
                        tmr_d   = note_load(entry_nxt[DUR_MSB:DUR_LSB]);
                    end else if (LOOP != 0) begin
                        restart = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        if (restart) begin
            idx_d = '0;
            if (entry0[DUR_MSB:DUR_LSB] != '0) begin
                state_d = ST_NOTE;
                tmr_d   = note_load(entry0[DUR_MSB:DUR_LSB]);
            end else begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        end
        if (play_stop) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Tone request: a pressed button overrides the melody note.
    always_comb begin
        entry_cur = melody_rom(idx_d);
        manual_d  = |btn;
        if (manual_d) begin
            tone_en_d = 1'b1;
            tone_hp_d = note_half_period(lowest_btn(btn));
        end else begin
            tone_en_d = (state_d == ST_NOTE) && !entry_cur[REST_BIT];
            tone_hp_d = note_half_period(entry_cur[NOTE_MSB:NOTE_LSB]);
        end
    end

    // State, timer and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            tmr_q    <= '0;
            busy_q   <= 1'b0;
            manual_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            busy_q   <= busy_d;
            manual_q <= manual_d;
        end
    end

    piezo_tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en_d),
        .half_period (tone_hp_d),
        .piezo       (piezo)
    );

    assign busy    = busy_q;
    assign cur_idx = idx_q;
    assign manual  = manual_q;

endmodule

// File: tb/tb_piezo_melody_ctrl.sv
// Bench for piezo_melody_ctrl: three configurations (short tick,
// long tick, looping) checked by vectors, sequences and a timeline model.
module tb_piezo_melody_ctrl;

    localparam int GAP = 2;
    localparam int TICKS [3] = '{10, 2000, 10};
    localparam int LOOPS [3] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] btn = 8'h00;
    logic       play_start = 1'b0;
    logic       play_stop = 1'b0;
    logic       piezo_o [3];
    logic       busy_o [3];
    logic [3:0] idx_o [3];
    logic       man_o [3];

    int ncmp = 0;
    int nfail = 0;
    int bcnt = 0;
    int brom [16];
    int hp_tab [8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

    bit m_act [3];
    int m_pos [3];
    int m_idx [3];
    bit m_en [3];
    int m_hp [3];
    int m_age [3];
    bit m_man;

    typedef struct {
        logic [7:0] btn;
        bit         start;
        bit         stop;
        int         n;
        int         busy;
        int         idx;
        int         man;
        int         pz;
    } vec_t;
    vec_t vt [11];

    always #5 clk = ~clk;

    piezo_melody_ctrl #(.TICK_UNIT(10), .GAP_CYCLES(GAP), .LOOP(0)) dut_a (
        .clk(clk), .rst(rst), .btn(btn), .play_start(play_start),
        .play_stop(play_stop), .piezo(piezo_o[0]), .busy(busy_o[0]),
        .cur_idx(idx_o[0]), .manual(man_o[0]));

    piezo_melody_ctrl #(.TICK_UNIT(2000), .GAP_CYCLES(GAP), .LOOP(0)) dut_b (
        .clk(clk), .rst(rst), .btn(btn), .play_start(play_start),
        .play_stop(play_stop), .piezo(piezo_o[1]), .busy(busy_o[1]),
        .cur_idx(idx_o[1]), .manual(man_o[1]));

    piezo_melody_ctrl #(.TICK_UNIT(10), .GAP_CYCLES(GAP), .LOOP(1)) dut_c (
        .clk(clk), .rst(rst), .btn(btn), .play_start(play_start),
        .play_stop(play_stop), .piezo(piezo_o[2]), .busy(busy_o[2]),
        .cur_idx(idx_o[2]), .manual(man_o[2]));

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Locate a timeline position inside the melody's note/gap segments.
    function automatic void locate(input int tick, input int pos,
                                   output int idx, output bit in_note);
        int base;
        int len;
        base = 0;
        idx = 0;
        in_note = 1'b0;
        for (int e = 0; e < 16; e++) begin
            if ((brom[e] & 15) == 0) break;
            len = (brom[e] & 15) * tick;
            if (pos < base + len) begin
                idx = e;
                in_note = 1'b1;
                return;
            end
            base += len;
            if (pos < base + GAP) begin
                idx = e;
                return;
            end
            base += GAP;
        end
    endfunction

    function automatic int total_len(input int tick);
        int t;
        t = 0;
        for (int e = 0; e < 16; e++) begin
            if ((brom[e] & 15) == 0) break;
            t += (brom[e] & 15) * tick + GAP;
        end
        return t;
    endfunction

    function automatic int low_bit(input logic [7:0] b);
        for (int i = 0; i < 8; i++) if (b[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_act[d] = 1'b0;
            m_pos[d] = 0;
            m_idx[d] = 0;
            m_en[d] = 1'b0;
            m_hp[d] = 0;
            m_age[d] = 0;
        end
        m_man = 1'b0;
    endtask

    // One clock of the reference: timeline position plus tone age.
    task automatic model_step();
        bit pressed;
        bit in_note;
        bit en;
        int idx;
        int hp;
        pressed = (btn != 8'h00);
        for (int d = 0; d < 3; d++) begin
            if (play_stop) begin
                m_act[d] = 1'b0;
            end else if (play_start) begin
                m_act[d] = 1'b1;
                m_pos[d] = 0;
            end else if (m_act[d] && !pressed) begin
                m_pos[d]++;
                if (m_pos[d] == total_len(TICKS[d])) begin
                    if (LOOPS[d] != 0) m_pos[d] = 0;
                    else m_act[d] = 1'b0;
                end
            end
            in_note = 1'b0;
            if (m_act[d]) begin
                locate(TICKS[d], m_pos[d], idx, in_note);
                m_idx[d] = idx;
            end
            en = 1'b0;
            hp = 0;
            if (pressed) begin
                en = 1'b1;
                hp = hp_tab[low_bit(btn)];
            end else if (m_act[d] && in_note && ((brom[m_idx[d]] & 128) == 0)) begin
                en = 1'b1;
                hp = hp_tab[(brom[m_idx[d]] >> 4) & 7];
            end
            if (!en || !m_en[d] || hp != m_hp[d]) m_age[d] = 0;
            else m_age[d]++;
            m_en[d] = en;
            m_hp[d] = hp;
        end
        m_man = pressed;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        if (busy_o[0]) bcnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse(input bit s, input bit p);
        play_start = s;
        play_stop = p;
        cyc();
        play_start = 1'b0;
        play_stop = 1'b0;
    endtask

    task automatic do_reset();
        btn = 8'h00;
        play_start = 1'b0;
        play_stop = 1'b0;
        rst = 1'b0;
        model_reset();
        run(2);
        rst = 1'b1;
    endtask

    int pz_exp;
    int hold;

    initial begin
        for (int e = 0; e < 16; e++) brom[e] = 0;
        brom[0] = 8'h01;
        brom[1] = 8'h82;
        brom[2] = 8'h21;

        vt[0]  = '{8'h00, 0, 0, 1,  0, 0, 0, 0};
        vt[1]  = '{8'h00, 1, 0, 1,  1, 0, 0, 0};
        vt[2]  = '{8'h00, 0, 0, 9,  1, 0, 0, 0};
        vt[3]  = '{8'h00, 0, 0, 1,  1, 0, 0, 0};
        vt[4]  = '{8'h00, 0, 0, 2,  1, 1, 0, 0};
        vt[5]  = '{8'h00, 0, 0, 20, 1, 1, 0, 0};
        vt[6]  = '{8'h00, 0, 0, 2,  1, 2, 0, 0};
        vt[7]  = '{8'h00, 0, 0, 11, 1, 2, 0, 0};
        vt[8]  = '{8'h00, 0, 0, 1,  0, -1, 0, 0};
        vt[9]  = '{8'h01, 0, 0, 1,  0, -1, 1, 0};
        vt[10] = '{8'h00, 0, 0, 1,  0, -1, 0, 0};

        model_reset();
        run(2);
        chk("rst_busy", busy_o[0], 0);
        chk("rst_idx", idx_o[0], 0);
        chk("rst_piezo", piezo_o[0], 0);
        chk("rst_manual", man_o[0], 0);
        rst = 1'b1;

        // Melody walk through the short-tick configuration.
        for (int v = 0; v < 11; v++) begin
            btn = vt[v].btn;
            pulse(vt[v].start, vt[v].stop);
            run(vt[v].n - 1);
            chk($sformatf("vec%0d_busy", v), busy_o[0], vt[v].busy);
            if (vt[v].idx >= 0)
                chk($sformatf("vec%0d_idx", v), idx_o[0], vt[v].idx);
            chk($sformatf("vec%0d_manual", v), man_o[0], vt[v].man);
            chk($sformatf("vec%0d_piezo", v), piezo_o[0], vt[v].pz);
        end
        btn = 8'h00;

        // Long tick: C4 half-period visible on the buzzer.
        do_reset();
        pulse(1, 0);
        run(1910);
        chk("c4_before_rise", piezo_o[1], 0);
        cyc();
        chk("c4_first_rise", piezo_o[1], 1);
        run(88);
        chk("c4_note_end", piezo_o[1], 1);
        cyc();
        chk("c4_gap_silent", piezo_o[1], 0);

        // Asynchronous reset in the middle of notes.
        do_reset();
        pulse(1, 0);
        run(1950);
        chk("prereset_piezo", piezo_o[1], 1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("async_piezo", piezo_o[1], 0);
        chk("async_busy", busy_o[1], 0);
        chk("async_busy_loop", busy_o[2], 0);
        chk("async_idx_end", idx_o[0], 0);
        chk("async_idx_loop", idx_o[2], 0);
        run(2);
        rst = 1'b1;
        run(3);
        chk("post_rst_busy", busy_o[2], 0);
        chk("post_rst_piezo", piezo_o[1], 0);
        chk("post_rst_idx", idx_o[2], 0);

        // Stop and start together: stop wins, index held.
        do_reset();
        pulse(1, 0);
        run(1950);
        chk("pre_stop_piezo", piezo_o[1], 1);
        chk("pre_stop_idx", idx_o[2], 1);
        pulse(1, 1);
        chk("stop_busy_b", busy_o[1], 0);
        chk("stop_piezo_b", piezo_o[1], 0);
        chk("stop_busy_c", busy_o[2], 0);
        chk("stop_idx_kept", idx_o[2], 1);

        // Button override freezes the melody for 500 cycles.
        do_reset();
        bcnt = 0;
        pulse(1, 0);
        run(4);
        btn = 8'b0010_0100;
        cyc();
        chk("ovr_manual", man_o[0], 1);
        run(499);
        chk("ovr_frozen_busy", busy_o[0], 1);
        chk("ovr_frozen_idx", idx_o[0], 0);
        btn = 8'h00;
        run(41);
        chk("ovr_released", man_o[0], 0);
        chk("ovr_still_busy", busy_o[0], 1);
        run(3);
        chk("ovr_done", busy_o[0], 0);
        chk("ovr_busy_cycles", bcnt, 546);

        // Override tone is E4 (lowest pressed bit).
        do_reset();
        btn = 8'b0010_0100;
        run(1517);
        chk("e4_before_rise", piezo_o[0], 0);
        cyc();
        chk("e4_rise", piezo_o[0], 1);
        run(1516);
        chk("e4_high_end", piezo_o[0], 1);
        cyc();
        chk("e4_fall", piezo_o[0], 0);
        btn = 8'h00;

        // Looping configuration wraps to entry 0.
        do_reset();
        pulse(1, 0);
        run(45);
        chk("loop_last_idx", idx_o[2], 2);
        cyc();
        chk("loop_wrap_busy", busy_o[2], 1);
        chk("loop_wrap_idx", idx_o[2], 0);
        chk("noloop_ends", busy_o[0], 0);
        run(12);
        chk("loop_second_idx", idx_o[2], 1);
        pulse(0, 1);
        chk("loop_stopped", busy_o[2], 0);

        // Restart during the last gap reloads a full note.
        do_reset();
        pulse(1, 0);
        run(44);
        chk("rs_gap_idx", idx_o[0], 2);
        pulse(1, 0);
        chk("rs_idx", idx_o[0], 0);
        chk("rs_busy", busy_o[0], 1);
        run(11);
        chk("rs_hold_idx", idx_o[0], 0);
        run(1);
        chk("rs_next_idx", idx_o[0], 1);

        // Random traffic against the timeline model.
        do_reset();
        hold = 0;
        play_start = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    btn = 8'($urandom_range(1, 255));
                    hold = $urandom_range(1, 2500);
                end else begin
                    btn = 8'h00;
                    hold = $urandom_range(1, 400);
                end
            end
            hold--;
            if (c > 0) begin
                play_start = ($urandom_range(0, 999) == 0);
                play_stop = ($urandom_range(0, 2999) == 0);
            end
            cyc();
            for (int d = 0; d < 3; d++) begin
                pz_exp = m_en[d] ? ((m_age[d] / m_hp[d]) % 2) : 0;
                chk($sformatf("rnd%0d_busy@%0d", d, c), busy_o[d], m_act[d]);
                chk($sformatf("rnd%0d_idx@%0d", d, c), idx_o[d], m_idx[d]);
                chk($sformatf("rnd%0d_manual@%0d", d, c), man_o[d], m_man);
                chk($sformatf("rnd%0d_piezo@%0d", d, c), piezo_o[d], pz_exp);
            end
        end
        play_start = 1'b0;
        play_stop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/piezo_melody_ctrl.md
Name: piezo_melody_ctrl

Overview:
- Sequencer/arbiter for the piezo output. It plays a 16-entry melody ROM autonomously and lets the 8 note buttons override it.
- Runs on the 1 MHz divided clock from the clock divider, alongside the existing button-tone path.
- The top level selects this block's piezo output.
- Contains one square-wave tone-generator sub-module.

Parameters:
- TICK_UNIT, 125000, clock cycles per duration unit (125 ms at 1 MHz).
- GAP_CYCLES, 20000, silent articulation gap between melody notes, in cycles.
- LOOP, 0, 1 = restart at entry 0 after the end of the melody; 0 = go idle.

Ports:
- clk  in  1  1 MHz clock
- rst  in  1  asynchronous, active-low reset
- btn  in  8  note buttons; bit i = note i (0 = C4 … 7 = C5); level-sensitive, already synchronised
- play_start  in  1  one-cycle pulse: start melody from entry 0
- play_stop  in  1  one-cycle pulse: abort melody
- piezo  out  1  square wave to the buzzer
- busy  out  1  melody sequence active (including while paused)
- cur_idx  out  4  current melody ROM index
- manual  out  1  a button currently owns the piezo

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; timers 0.
- ROM entry format (8 bits): [7] rest, [6:4] note, [3:0] dur. dur = 0 is the end marker.
- Note half-period table in cycles: 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956.
- FSM states:
  - IDLE: busy = 0.
  - NOTE: tone enabled unless rest = 1; timer counts dur*TICK_UNIT cycles.
  - GAP: tone disabled; timer counts GAP_CYCLES cycles.
- Transitions:
  - IDLE→NOTE on play_start: cur_idx = 0, busy = 1 the next cycle. If entry 0 has dur = 0, go back to IDLE immediately.
  - NOTE→GAP when the timer expires.
  - GAP→NOTE at cur_idx+1 when the timer expires.
  - If the next entry is the end marker, or cur_idx was 15: go to IDLE (LOOP = 0) or to NOTE at index 0 (LOOP = 1).
  - cur_idx wraps 15→0 only when LOOP = 1.
- Any state → IDLE on play_stop; cur_idx is kept.
- play_start and play_stop in the same cycle: stop wins.
- play_start while busy: restart at entry 0 with a fresh timer.
- Button override:
  - When btn ≠ 0: manual = 1, and the tone is the lowest-index set bit's half-period.
  - FSM timers freeze (pause) while manual = 1.
  - Release resumes with the remaining count.
  - play_start and play_stop are still honoured during override.
- Tone selection changes take effect on the cycle after the input change; the generator restarts its counter on any half-period change or enable edge.
- Timer width is 24 bits; dur*TICK_UNIT must fit.
- Tone generator:
  - Counter 0..hp-1; piezo toggles when the counter reaches hp-1.
  - First rising edge occurs hp cycles after enable is registered.
  - When disabled: piezo = 0 and counter = 0.

Decomposition:
- Shared package: note half-period table, ROM field positions, NUM_NOTES = 8, ROM_DEPTH = 16.
- Melody ROM contents live as a constant function in the package.
- Sub-module: piezo_tone_gen (clk, rst, en, half_period[11:0], piezo).

Test Plan (TICK_UNIT = 10, GAP_CYCLES = 2, ROM = {C4 d1, rest d2, E4 d1, end}):
- Reset mid-note: rst low mid-note → piezo = 0, busy = 0, cur_idx = 0 immediately (async); outputs stay 0 after release.
- Melody: play_start → busy = 1 next cycle. Sequence is:
  - NOTE 10 cycles, first piezo rise 1911 cycles after tone enable (piezo stays 0 for a 10-cycle note);
  - GAP 2;
  - rest 20 with piezo = 0;
  - GAP 2;
  - idx 2 for 10;
  - GAP 2.
  busy falls at the end marker, 46 cycles after start. Repeat with TICK_UNIT = 2000 to see the 1911-cycle half-period toggling.
- Override: btn = 8'b0010_0100 mid-note → manual = 1, half-period 1517 (E4), timer frozen. Release after 500 cycles → the note finishes its remaining cycles; total busy = 546.
- Stop priority: play_start and play_stop in the same cycle while busy → IDLE, busy = 0, piezo = 0.
- LOOP = 1: after the end marker, cur_idx returns to 0 and busy stays 1. play_stop ends it.
- Restart: play_start during GAP at idx 2 → cur_idx = 0 and the NOTE timer reloads to 10.
